risc_muldiv_unit: RTL and testbench

RISC_MULDIV_UNIT -- requirements
Module: risc_muldiv_unit

---
 rtl/risc_muldiv_unit.sv | 153 +++++++++++++++
 tb/tb_risc_muldiv_unit.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/risc_muldiv_unit.sv
// RV32M multiply/divide unit: 32-cycle shift-add multiply and restoring divide on
// operand magnitudes, sign fixed up at writeback; divide-by-zero/overflow bypass to DONE.
module risc_muldiv_unit (
  input  logic        clk,
  input  logic        rset_lg,
  input  logic        start,
  input  logic [2:0]  funct3,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic [4:0]  rd_in,
  output logic        busy,
  output logic        done,
  output logic        wb_we,
  output logic [31:0] wb_wd,
  output logic [4:0]  wb_addr,
  output logic [1:0]  o_dbg_state
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t      r_state, w_next;
  logic [2:0]  r_f3;
  logic [4:0]  r_rd;
  logic [4:0]  r_cnt;
  logic        r_neg;
  logic        r_spec;
  logic [31:0] r_spec_val;
  logic [63:0] r_mcand;
  logic [31:0] r_mplier;
  logic [63:0] r_prod;
  logic [31:0] r_quot;
  logic [31:0] r_rem;
  logic [31:0] r_dvsr;

  logic        w_a_sgn, w_b_sgn, w_a_neg, w_b_neg;
  logic [31:0] w_a_mag, w_b_mag, w_spec_val;
  logic        w_div0, w_ovf, w_neg_in;
  logic [32:0] w_trial;
  logic [63:0] w_prod_s;
  logic [31:0] w_quot_s, w_rem_s, w_result;

  // Signedness per op: DIV/REM signed, DIVU/REMU unsigned; MULHSU has only a signed.
  assign w_a_sgn    = funct3[2] ? ~funct3[0] : (funct3[1:0] != 2'b11);
  assign w_b_sgn    = funct3[2] ? ~funct3[0] : ~funct3[1];
  assign w_a_neg    = w_a_sgn & op_a[31];
  assign w_b_neg    = w_b_sgn & op_b[31];
  assign w_a_mag    = w_a_neg ? (~op_a + 32'd1) : op_a;
  assign w_b_mag    = w_b_neg ? (~op_b + 32'd1) : op_b;
  assign w_div0     = funct3[2] & (op_b == 32'd0);
  assign w_ovf      = funct3[2] & ~funct3[0] & (op_a == 32'h8000_0000) & (op_b == 32'hFFFF_FFFF);
  assign w_spec_val = w_div0 ? (funct3[1] ? op_a : 32'hFFFF_FFFF)
                             : (funct3[1] ? 32'd0 : 32'h8000_0000);
  // Remainder follows the dividend's sign; quotient and product use the XOR.
  assign w_neg_in   = (funct3[2] & funct3[1]) ? w_a_neg : (w_a_neg ^ w_b_neg);

  assign w_trial = {r_rem, r_quot[31]} - {1'b0, r_dvsr};

  always_ff @(posedge clk or posedge rset_lg) begin
    if (rset_lg) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (w_div0 || w_ovf) w_next = S_DONE;
          else if (funct3[2])  w_next = S_DIV;
          else                 w_next = S_MUL;
        end
      end
      S_MUL:   if (r_cnt == 5'd31) w_next = S_DONE;
      S_DIV:   if (r_cnt == 5'd31) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rset_lg) begin
    if (rset_lg) begin
      r_f3       <= 3'd0;
      r_rd       <= 5'd0;
      r_cnt      <= 5'd0;
      r_neg      <= 1'b0;
      r_spec     <= 1'b0;
      r_spec_val <= 32'd0;
      r_mcand    <= 64'd0;
      r_mplier   <= 32'd0;
      r_prod     <= 64'd0;
      r_quot     <= 32'd0;
      r_rem      <= 32'd0;
      r_dvsr     <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_f3       <= funct3;
            r_rd       <= rd_in;
            r_cnt      <= 5'd0;
            r_neg      <= w_neg_in;
            r_spec     <= w_div0 | w_ovf;
            r_spec_val <= w_spec_val;
            r_mcand    <= {32'd0, w_a_mag};
            r_mplier   <= w_b_mag;
            r_prod     <= 64'd0;
            r_quot     <= w_a_mag;
            r_rem      <= 32'd0;
            r_dvsr     <= w_b_mag;
          end
        end
        S_MUL: begin
          if (r_mplier[0]) r_prod <= r_prod + r_mcand;
          r_mcand  <= {r_mcand[62:0], 1'b0};
          r_mplier <= {1'b0, r_mplier[31:1]};
          r_cnt    <= r_cnt + 5'd1;
        end
        S_DIV: begin
          // Dividend bits shift out of r_quot's top while quotient bits shift in below.
          if (!w_trial[32]) begin
            r_rem  <= w_trial[31:0];
            r_quot <= {r_quot[30:0], 1'b1};
          end else begin
            r_rem  <= {r_rem[30:0], r_quot[31]};
            r_quot <= {r_quot[30:0], 1'b0};
          end
          r_cnt <= r_cnt + 5'd1;
        end
        default: ;
      endcase
    end
  end

  assign w_prod_s = r_neg ? (~r_prod + 64'd1) : r_prod;
  assign w_quot_s = r_neg ? (~r_quot + 32'd1) : r_quot;
  assign w_rem_s  = r_neg ? (~r_rem + 32'd1) : r_rem;

  always_comb begin
    w_result = 32'd0;
    if (r_spec)                 w_result = r_spec_val;
    else if (r_f3[2])           w_result = r_f3[1] ? w_rem_s : w_quot_s;
    else if (r_f3[1:0] == 2'd0) w_result = w_prod_s[31:0];
    else                        w_result = w_prod_s[63:32];
  end

  assign busy        = (r_state != S_IDLE);
  assign done        = (r_state == S_DONE);
  assign wb_we       = done & (r_rd != 5'd0);
  assign wb_wd       = done ? w_result : 32'd0;
  assign wb_addr     = done ? r_rd : 5'd0;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_risc_muldiv_unit.sv
// Self-checking bench for risc_muldiv_unit: directed RV32M vectors plus random ops
// checked against an arithmetic reference model, with latency and pulse checks.
module tb_risc_muldiv_unit;

  logic        clk = 1'b0;
  logic        rset_lg;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [4:0]  rd_in;
  logic        busy;
  logic        done;
  logic        wb_we;
  logic [31:0] wb_wd;
  logic [4:0]  wb_addr;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  risc_muldiv_unit dut (
    .clk(clk), .rset_lg(rset_lg), .start(start), .funct3(funct3),
    .op_a(op_a), .op_b(op_b), .rd_in(rd_in), .busy(busy), .done(done),
    .wb_we(wb_we), .wb_wd(wb_wd), .wb_addr(wb_addr), .o_dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // RV32M result from plain 64-bit / 32-bit integer arithmetic.
  function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a,
                                            input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    int ia, ib;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    ia = $signed(a);
    ib = $signed(b);
    p  = 64'd0;
    case (f)
      3'd0: begin p = 64'(sa * sb); return p[31:0];  end
      3'd1: begin p = 64'(sa * sb); return p[63:32]; end
      3'd2: begin p = 64'(sa * ub); return p[63:32]; end
      3'd3: begin p = 64'(ua * ub); return p[63:32]; end
      default: begin
        if (b == 32'd0) return f[1] ? a : 32'hFFFF_FFFF;
        if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
          return f[1] ? 32'd0 : 32'h8000_0000;
        case (f)
          3'd4:    return 32'(ia / ib);
          3'd5:    return a / b;
          3'd6:    return 32'(ia % ib);
          default: return a % b;
        endcase
      end
    endcase
  endfunction

  // Called at a negedge with the DUT idle; returns at the negedge one cycle after done.
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input bit scramble, input bit hold_start,
                        input string name);
    logic [31:0] exp;
    int k;
    int exp_lat;
    bit is_spec;
    exp_q.push_back(ref_model(f, a, b));
    is_spec = f[2] && (b == 32'd0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    exp_lat = is_spec ? 1 : 33;
    start = 1'b1; funct3 = f; op_a = a; op_b = b; rd_in = rd;
    @(negedge clk);
    start = 1'b0;
    k = 1;
    while (done !== 1'b1 && k < 100) begin
      checks++;
      if (busy !== 1'b1) begin
        errors++;
        $display("FAIL %s busy: got %b expected 1 at cycle %0d", name, busy, k);
      end
      if (scramble) begin
        start  = 1'($urandom_range(0, 1));
        funct3 = 3'($urandom_range(0, 7));
        op_a   = $urandom;
        op_b   = $urandom;
        rd_in  = 5'($urandom_range(0, 31));
      end
      @(negedge clk);
      k++;
    end
    exp = exp_q.pop_front();
    start = hold_start;
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL %s done: got %b expected 1 within 100 cycles", name, done);
    end
    checks++;
    if (k != exp_lat) begin
      errors++;
      $display("FAIL %s latency: got %0d expected %0d", name, k, exp_lat);
    end
    checks++;
    if (wb_wd !== exp) begin
      errors++;
      $display("FAIL %s wb_wd: got %h expected %h", name, wb_wd, exp);
    end
    checks++;
    if (wb_addr !== rd || wb_we !== (rd != 5'd0) || busy !== 1'b1) begin
      errors++;
      $display("FAIL %s wb: got addr=%0d we=%b busy=%b expected addr=%0d we=%b busy=1",
               name, wb_addr, wb_we, busy, rd, (rd != 5'd0));
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || wb_we !== 1'b0 || wb_wd !== 32'd0 || wb_addr !== 5'd0) begin
      errors++;
      $display("FAIL %s after_done: got done=%b busy=%b we=%b wd=%h addr=%0d expected all 0",
               name, done, busy, wb_we, wb_wd, wb_addr);
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rset_lg = 1'b1;
    start = 1'b1; funct3 = 3'd4; op_a = $urandom; op_b = $urandom; rd_in = 5'd7;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || wb_we !== 1'b0 || wb_wd !== 32'd0 ||
        wb_addr !== 5'd0 || dbg_state !== 2'd0) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%b done=%b we=%b wd=%h addr=%0d st=%0d expected all 0",
               busy, done, wb_we, wb_wd, wb_addr, dbg_state);
    end
    rset_lg = 1'b0;
    start = 1'b0;
    run_op(3'd0, 32'd11, 32'd13, 5'd1, 1'b0, 1'b0, "first_after_reset");
  endtask

  task automatic test_directed();
    run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5, 1'b0, 1'b0, "mul_7_m3");
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, 1'b0, 1'b0, "mulhu_max");
    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, 1'b0, 1'b0, "mulh_m1");
    run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8, 1'b0, 1'b0, "mulhsu_m1");
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd10, 1'b0, 1'b0, "div_m7_2");
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd11, 1'b0, 1'b0, "rem_m7_2");
    run_op(3'd5, 32'd100, 32'd7, 5'd12, 1'b0, 1'b0, "divu_100_7");
    run_op(3'd4, 32'h0000_1234, 32'd0, 5'd13, 1'b0, 1'b0, "div_by_zero");
    run_op(3'd7, 32'h0000_1234, 32'd0, 5'd14, 1'b0, 1'b0, "remu_by_zero");
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 1'b0, 1'b0, "div_overflow");
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 1'b0, 1'b0, "rem_overflow");
    run_op(3'd5, 32'h8000_0000, 32'hFFFF_FFFF, 5'd17, 1'b0, 1'b0, "divu_no_overflow");
    run_op(3'd0, 32'd3, 32'd4, 5'd0, 1'b0, 1'b0, "mul_rd0");
  endtask

  task automatic test_ignore_start();
    run_op(3'd0, 32'd1234, 32'd5678, 5'd20, 1'b1, 1'b0, "mul_restart_ignored");
    run_op(3'd6, 32'hF000_0001, 32'd77, 5'd21, 1'b1, 1'b0, "rem_inputs_change");
  endtask

  task automatic test_random();
    logic [2:0] f;
    logic [31:0] a, b;
    for (int i = 0; i < 40; i++) begin
      f = 3'($urandom_range(0, 7));
      a = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 9))
        0:       b = 32'd0;
        1:       b = 32'hFFFF_FFFF;
        2:       b = 32'($urandom_range(1, 15));
        default: b = $urandom;
      endcase
      run_op(f, a, b, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), 1'b0, "random");
    end
  endtask

  task automatic test_reset_abort();
    int done_seen;
    start = 1'b1; funct3 = 3'd4; op_a = 32'd1000; op_b = 32'd7; rd_in = 5'd9;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rset_lg = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || wb_we !== 1'b0) begin
      errors++;
      $display("FAIL abort_reset: got busy=%b done=%b we=%b expected 0", busy, done, wb_we);
    end
    @(negedge clk);
    rset_lg = 1'b0;
    done_seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1 || wb_we === 1'b1 || busy === 1'b1) done_seen++;
    end
    checks++;
    if (done_seen != 0) begin
      errors++;
      $display("FAIL abort_no_done: got %0d active cycles expected 0", done_seen);
    end
    run_op(3'd4, 32'd1000, 32'd7, 5'd9, 1'b0, 1'b0, "div_after_abort");
  endtask

  task automatic test_back_to_back();
    run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd2, 1'b0, 1'b1, "b2b_mulh");
    run_op(3'd5, 32'hDEAD_BEEF, 32'd0, 5'd3, 1'b0, 1'b1, "b2b_divu0");
    run_op(3'd7, 32'hDEAD_BEEF, 32'h0001_0001, 5'd4, 1'b0, 1'b0, "b2b_remu");
  endtask

  initial begin
    rset_lg = 1'b1;
    start = 1'b0; funct3 = 3'd0; op_a = 32'd0; op_b = 32'd0; rd_in = 5'd0;
    @(negedge clk);
    test_reset();
    test_directed();
    test_ignore_start();
    test_random();
    test_reset_abort();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
